// File: rtl/issue_queue_if.sv
// Shared entry type and decode/issue-side interface for issue_queue.
//
// issue_queue_pkg::ISSUE_QUEUE_ELEMENT : one decoded instruction slot.
//
// issue_queue_if #(DEPTH) signals:
//   push_number   producer -> queue  entries written this cycle (0..2)
//   push_data     producer -> queue  [0] older, [1] younger entry
//   iq_stall      queue -> producer  back-pressure
//   issue_require queue -> consumer  [0] head, [1] head+1 (zero when absent)
//   iq_size       queue -> consumer  min(count, 2)
//   iq_pop_number consumer -> queue  entries consumed this cycle (0..2)
//   iq_count      queue -> consumer  true occupancy
// Modports: master = decode/issue side (testbench), slave = queue.
package issue_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ISSUE_QUEUE_ELEMENT;
endpackage

interface issue_queue_if
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
);
  logic [1:0]                   push_number;
  ISSUE_QUEUE_ELEMENT [1:0]     push_data;
  logic                         iq_stall;
  ISSUE_QUEUE_ELEMENT [1:0]     issue_require;
  logic [1:0]                   iq_size;
  logic [1:0]                   iq_pop_number;
  logic [$clog2(DEPTH):0]       iq_count;

  modport master (
    output push_number, push_data, iq_pop_number,
    input  iq_stall, issue_require, iq_size, iq_count
  );

  modport slave (
    input  push_number, push_data, iq_pop_number,
    output iq_stall, issue_require, iq_size, iq_count
  );
endinterface

// File: rtl/issue_queue.sv
// Dual-push / dual-pop circular FIFO between decode and issue.
// Decode writes up to two entries per cycle, issue sees the two oldest
// entries and pops 0..2 per cycle; flush empties the queue in one cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   flush  synchronous clear, priority over push and pop
//   q      issue_queue_if.slave (push/pop handshake, status outputs)
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  issue_queue_if.slave q
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  ptr_t               head_q, head_d;
  ptr_t               tail_q, tail_d;
  cnt_t               count_q, count_d;
  ISSUE_QUEUE_ELEMENT mem_q [DEPTH];

  ptr_t       head_p1, tail_p1;
  logic       stall;
  logic [1:0] size;
  logic [1:0] push_req, push_eff, pop_eff;
  logic       we0, we1;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign head_p1 = head_q + ptr_t'(1);
  assign tail_p1 = tail_q + ptr_t'(1);

  // Stall looks at registered count only, so two accepted entries always
  // fit even when nothing is popped this cycle.
  always_comb begin
    stall = (count_q > cnt_t'(DEPTH - 2));

    if (count_q >= cnt_t'(2)) size = 2'd2;
    else                      size = count_q[1:0];

    push_req = (q.push_number == 2'd3) ? 2'd2 : q.push_number;
    push_eff = stall ? 2'd0 : push_req;

    // Any request above the visible size (including 3) is clamped.
    pop_eff  = (q.iq_pop_number > size) ? size : q.iq_pop_number;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    we0     = 1'b0;
    we1     = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      we0     = (push_eff != 2'd0);
      we1     = (push_eff == 2'd2);
      head_d  = head_q + ptr_t'(pop_eff);
      tail_d  = tail_q + ptr_t'(push_eff);
      count_d = count_q + cnt_t'(push_eff) - cnt_t'(pop_eff);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; entries beyond count are masked on the read side.
  always_ff @(posedge clk) begin
    if (we0) mem_q[tail_q]  <= q.push_data[0];
    if (we1) mem_q[tail_p1] <= q.push_data[1];
  end

  always_comb begin
    q.issue_require = '0;
    if (count_q >= cnt_t'(1)) q.issue_require[0] = mem_q[head_q];
    if (count_q >= cnt_t'(2)) q.issue_require[1] = mem_q[head_p1];
    q.iq_size  = size;
    q.iq_stall = stall;
    q.iq_count = count_q;
  end

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  issue_queue_if #(.DEPTH(DEPTH)) qif ();

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q     (qif.slave)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       fl;
    logic [1:0] pn;
    int         d0;
    int         d1;
    logic [1:0] pop;
    int         cnt;
    int         sz;
    logic       st;
    int         r0;
    int         r1;
  } vec_t;

  vec_t tbl [16];

  function automatic ISSUE_QUEUE_ELEMENT mk(input int t);
    ISSUE_QUEUE_ELEMENT e;
    e.pc   = 32'h0000_1000 + t;
    e.inst = 32'hA500_0000 | t;
    return e;
  endfunction

  // Tag 0 stands for an absent entry, which must read as all-zero.
  function automatic ISSUE_QUEUE_ELEMENT ex(input int t);
    ISSUE_QUEUE_ELEMENT e;
    e = (t == 0) ? '0 : mk(t);
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    else
      passed++;
  endtask

  // Drive inputs, take one rising edge, settle #1 past it.
  task automatic drive(input logic fl, input logic [1:0] pn, input int d0, input int d1,
                       input logic [1:0] pop);
    flush             = fl;
    qif.push_number   = pn;
    qif.push_data[0]  = mk(d0);
    qif.push_data[1]  = mk(d1);
    qif.iq_pop_number = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int cnt, input int sz, input logic st,
                             input int r0, input int r1);
    check({tag, " count"}, 64'(qif.iq_count), 64'(cnt));
    check({tag, " size"},  64'(qif.iq_size),  64'(sz));
    check({tag, " stall"}, 64'(qif.iq_stall), 64'(st));
    check({tag, " req0"},  qif.issue_require[0], ex(r0));
    check({tag, " req1"},  qif.issue_require[1], ex(r1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                fl    pn    d0  d1  pop   cnt sz st    r0  r1
    tbl[0]  = '{1'b0, 2'd1,  1,  0, 2'd0,  1, 1, 1'b0,  1,  0};
    tbl[1]  = '{1'b0, 2'd2,  2,  3, 2'd0,  3, 2, 1'b0,  1,  2};
    tbl[2]  = '{1'b0, 2'd0,  0,  0, 2'd3,  1, 1, 1'b0,  3,  0};
    tbl[3]  = '{1'b0, 2'd0,  0,  0, 2'd2,  0, 0, 1'b0,  0,  0};
    tbl[4]  = '{1'b0, 2'd2,  4,  5, 2'd0,  2, 2, 1'b0,  4,  5};
    tbl[5]  = '{1'b0, 2'd2,  6,  7, 2'd0,  4, 2, 1'b0,  4,  5};
    tbl[6]  = '{1'b0, 2'd2,  8,  9, 2'd0,  6, 2, 1'b0,  4,  5};
    tbl[7]  = '{1'b0, 2'd2, 10, 11, 2'd0,  8, 2, 1'b1,  4,  5};
    tbl[8]  = '{1'b0, 2'd2, 12, 13, 2'd1,  7, 2, 1'b1,  5,  6};
    tbl[9]  = '{1'b0, 2'd2, 12, 13, 2'd0,  7, 2, 1'b1,  5,  6};
    tbl[10] = '{1'b0, 2'd0,  0,  0, 2'd1,  6, 2, 1'b0,  6,  7};
    tbl[11] = '{1'b0, 2'd3, 12, 13, 2'd0,  8, 2, 1'b1,  6,  7};
    tbl[12] = '{1'b0, 2'd0,  0,  0, 2'd2,  6, 2, 1'b0,  8,  9};
    tbl[13] = '{1'b1, 2'd2, 14, 15, 2'd2,  0, 0, 1'b0,  0,  0};
    tbl[14] = '{1'b0, 2'd1, 16,  0, 2'd0,  1, 1, 1'b0, 16,  0};
    tbl[15] = '{1'b0, 2'd0,  0,  0, 2'd1,  0, 0, 1'b0,  0,  0};

    rst               = 1'b0;
    flush             = 1'b0;
    qif.push_number   = 2'd0;
    qif.push_data     = '0;
    qif.iq_pop_number = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0, 1'b0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].fl, tbl[i].pn, tbl[i].d0, tbl[i].d1, tbl[i].pop);
      check_state($sformatf("v%0d", i), tbl[i].cnt, tbl[i].sz, tbl[i].st, tbl[i].r0, tbl[i].r1);
    end

    // Steady 2-in/2-out starting at head=1; head passes 7 and wraps to 0.
    drive(1'b0, 2'd2, 100, 101, 2'd0);
    check_state("wrap0", 2, 2, 1'b0, 100, 101);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 2'd2, 100 + 2 * k, 101 + 2 * k, 2'd2);
      check_state($sformatf("wrap%0d", k), 2, 2, 1'b0, 100 + 2 * k, 101 + 2 * k);
    end
    drive(1'b0, 2'd0, 0, 0, 2'd2);
    check_state("drain", 0, 0, 1'b0, 0, 0);

    // Asynchronous reset with five entries held, mid-cycle.
    drive(1'b0, 2'd2, 200, 201, 2'd0);
    drive(1'b0, 2'd2, 202, 203, 2'd0);
    drive(1'b0, 2'd1, 204, 0, 2'd0);
    check_state("pre_rst", 5, 2, 1'b0, 200, 201);
    qif.push_number = 2'd0;
    #2;
    rst = 1'b0;
    #1;
    check_state("async_rst", 0, 0, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 2'd0, 0, 0, 2'd0);
    check_state("post_rst", 0, 0, 1'b0, 0, 0);
    drive(1'b0, 2'd1, 210, 0, 2'd0);
    check_state("post_rst_push", 1, 1, 1'b0, 210, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
